// File: rtl/i2c_nunchuk_target.sv
// i2c_nunchuk_target: I2C target that emulates a Nunchuk controller at address ADDR.
// Accepts the init write and the register-pointer write, and serves a NUM_BYTES report
// on reads from a snapshot taken during the address ACK. Never stretches SCL.
// Optional feature macro: NUNCHUK_ENC_EN (legacy byte encoding of transmitted data).
module i2c_nunchuk_target #(
    parameter logic [6:0] ADDR      = 7'h52,
    parameter int         NUM_BYTES = 6,
    parameter logic [7:0] INIT_REG  = 8'h40
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   scl_i,
    input  logic                   sda_i,
    output logic                   sda_oe,
    input  logic [8*NUM_BYTES-1:0] report,
    output logic                   init_done,
    output logic                   rd_strobe,
    output logic                   busy,
    output logic [7:0]             reg_ptr
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_BYTE,
        ST_WR_ACK, ST_RD_BYTE, ST_RD_ACK, ST_IGNORE
    } state_t;

    logic                   scl_meta_q, scl_sync_q, scl_prev_q;
    logic                   sda_meta_q, sda_sync_q, sda_prev_q;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    state_t                 state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   rw_q, rw_d;
    logic                   first_q, first_d;
    logic                   sda_oe_q, sda_oe_d;
    logic                   init_done_q, init_done_d;
    logic                   rd_strobe_q, rd_strobe_d;
    logic                   busy_q, busy_d;
    logic [7:0]             reg_ptr_q, reg_ptr_d;
    logic [8*NUM_BYTES-1:0] snap_q, snap_d;
    logic [7:0]             rx_byte, tx_raw, tx_byte;
`ifdef NUNCHUK_ENC_EN
    logic                   enc_q, enc_d;
`endif

    // Two-stage synchronizers plus one history stage; snapshot register follows its _d.
    // NOTE: these flops carry no reset: the chain keeps tracking the pads through reset so
    // no false START/STOP appears when reset drops, and the snapshot is always reloaded
    // before it is read.
    always_ff @(posedge clk_in) begin
        // NOTE: non-blocking so each stage captures the previous stage's old value;
        // blocking assignments here would collapse the chain into one flop.
        scl_meta_q <= scl_i;
        scl_sync_q <= scl_meta_q;
        scl_prev_q <= scl_sync_q;
        sda_meta_q <= sda_i;
        sda_sync_q <= sda_meta_q;
        sda_prev_q <= sda_sync_q;
        snap_q     <= snap_d;
    end

    assign scl_rise  =  scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q &  scl_prev_q;
    assign start_det =  scl_sync_q &  scl_prev_q &  sda_prev_q & ~sda_sync_q;
    assign stop_det  =  scl_sync_q &  scl_prev_q & ~sda_prev_q &  sda_sync_q;
    assign rx_byte   = {shift_q[6:0], sda_sync_q};

    // Select the byte to transmit at the current pointer (filler beyond the report).
    always_comb begin
        tx_raw = 8'hFF;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (reg_ptr_q == 8'(i)) tx_raw = snap_q[8*(NUM_BYTES-1-i) +: 8];
        end
`ifdef NUNCHUK_ENC_EN
        tx_byte = enc_q ? ((tx_raw ^ 8'h17) + 8'h17) : tx_raw;
`else
        tx_byte = tx_raw;
`endif
    end

    // Next-state and next-output logic for the target FSM.
    always_comb begin
        // NOTE: every _d starts from its _q, so no branch can leave it unassigned (no latch).
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        first_d     = first_q;
        sda_oe_d    = sda_oe_q;
        init_done_d = init_done_q;
        rd_strobe_d = 1'b0;
        busy_d      = busy_q;
        reg_ptr_d   = reg_ptr_q;
        snap_d      = snap_q;
`ifdef NUNCHUK_ENC_EN
        enc_d       = enc_q;
`endif
        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            if (state_q == ST_RD_BYTE || state_q == ST_RD_ACK) rd_strobe_d = 1'b1;
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        if (rx_byte[7:1] == ADDR) begin
                            state_d = ST_ADDR_ACK;
                            busy_d  = 1'b1;
                            rw_d    = rx_byte[0];
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                // bit_cnt 0: waiting for the fall that opens the ACK slot; 1: ACK driven.
                ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
                    if (bit_cnt_q == 4'd0) begin
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = 4'd1;
                        if (state_q == ST_ADDR_ACK && rw_q) snap_d = report;
                    end else begin
                        bit_cnt_d = 4'd0;
                        if (state_q == ST_ADDR_ACK && rw_q) begin
                            shift_d  = tx_byte;
                            sda_oe_d = ~tx_byte[7];
                            state_d  = ST_RD_BYTE;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WR_BYTE;
                            if (state_q == ST_ADDR_ACK) first_d = 1'b1;
                        end
                    end
                end
                ST_WR_BYTE: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        state_d   = ST_WR_ACK;
                        if (first_q) begin
                            reg_ptr_d = rx_byte;
                            first_d   = 1'b0;
                        end else begin
                            if (reg_ptr_q == INIT_REG) begin
                                init_done_d = 1'b1;
`ifdef NUNCHUK_ENC_EN
                                if (rx_byte == 8'h00) enc_d = 1'b1;
`endif
                            end
`ifdef NUNCHUK_ENC_EN
                            if (reg_ptr_q == 8'hF0 && rx_byte == 8'h55) enc_d = 1'b0;
`endif
                            reg_ptr_d = reg_ptr_q + 8'd1;
                        end
                    end
                end
                // bit_cnt counts rising edges of the byte being sent; shift_q[7] is on the wire.
                ST_RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            reg_ptr_d = reg_ptr_q + 8'd1;
                            bit_cnt_d = 4'd0;
                            state_d   = ST_RD_ACK;
                        end else if (bit_cnt_q != 4'd0) begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end else begin
                            sda_oe_d = ~shift_q[7];
                        end
                    end
                end
                ST_RD_ACK: if (scl_rise) begin
                    if (!sda_sync_q) begin
                        shift_d   = tx_byte;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RD_BYTE;
                    end else begin
                        rd_strobe_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = ST_IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and registered outputs with synchronous active-high reset.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            first_q     <= 1'b0;
            sda_oe_q    <= 1'b0;
            init_done_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            busy_q      <= 1'b0;
            reg_ptr_q   <= 8'h00;
`ifdef NUNCHUK_ENC_EN
            enc_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            first_q     <= first_d;
            sda_oe_q    <= sda_oe_d;
            init_done_q <= init_done_d;
            rd_strobe_q <= rd_strobe_d;
            busy_q      <= busy_d;
            reg_ptr_q   <= reg_ptr_d;
`ifdef NUNCHUK_ENC_EN
            enc_q       <= enc_d;
`endif
        end
    end

    assign sda_oe    = sda_oe_q;
    assign init_done = init_done_q;
    assign rd_strobe = rd_strobe_q;
    assign busy      = busy_q;
    assign reg_ptr   = reg_ptr_q;

endmodule

// File: tb/tb_i2c_nunchuk_target.sv
// Testbench for i2c_nunchuk_target: bit-banged I2C master over an open-drain SDA model,
// ~12 MHz system clock, ~100 kHz SCL. Read data is checked through an expected-byte queue.
`timescale 1ns/1ps
module tb_i2c_nunchuk_target;

    localparam int QTR = 30;   // system clocks per quarter SCL period
    localparam int NB  = 6;

    logic            clk_in = 1'b0;
    logic            reset  = 1'b1;
    logic            scl    = 1'b1;
    logic            msda   = 1'b1;
    logic            sda_line;
    logic            sda_oe, init_done, rd_strobe, busy;
    logic [7:0]      reg_ptr;
    logic [8*NB-1:0] report = '0;

    int         total = 0, passed = 0, failed = 0;
    int         strobe_cnt = 0, oe_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_ptr  = 8'h00;
    logic       model_init = 1'b0;
    logic       model_enc  = 1'b0;

    assign sda_line = msda & ~sda_oe;

    i2c_nunchuk_target dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .scl_i     (scl),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .report    (report),
        .init_done (init_done),
        .rd_strobe (rd_strobe),
        .busy      (busy),
        .reg_ptr   (reg_ptr)
    );

    always #42 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (rd_strobe) strobe_cnt++;
        if (sda_oe) oe_cnt++;
    end

    initial begin
        #50_000_000;
        $display("FAIL watchdog: run did not finish (passed %0d of %0d)", passed, total);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    function automatic logic [7:0] xform(input logic [7:0] b);
        if (model_enc) return (b ^ 8'h17) + 8'h17;
        return b;
    endfunction

    task automatic i2c_start();
        msda = 1'b1; tick(QTR);
        scl  = 1'b1; tick(QTR);
        msda = 1'b0; tick(QTR);
        scl  = 1'b0; tick(QTR);
    endtask

    task automatic i2c_stop();
        msda = 1'b0; tick(QTR);
        scl  = 1'b1; tick(QTR);
        msda = 1'b1; tick(QTR);
    endtask

    task automatic write_bit(input logic b);
        msda = b;    tick(QTR);
        scl  = 1'b1; tick(2*QTR);
        scl  = 1'b0; tick(QTR);
    endtask

    task automatic read_bit(output logic b);
        msda = 1'b1; tick(QTR);
        scl  = 1'b1; tick(QTR);
        b    = sda_line; tick(QTR);
        scl  = 1'b0; tick(QTR);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
        ack = ~a;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        write_bit(nack);
    endtask

    // Write transaction: address/W then n (1..3) data bytes, tracking the pointer model.
    task automatic send_write(input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input int n);
        logic       ack;
        logic [7:0] d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        i2c_start();
        write_byte(8'hA4, ack);
        check("wr addr ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            write_byte(d[i], ack);
            check($sformatf("wr data %0d ack", i), ack, 1);
            if (i == 0) begin
                model_ptr = d[i];
            end else begin
                if (model_ptr == 8'h40) begin
                    model_init = 1'b1;
`ifdef NUNCHUK_ENC_EN
                    if (d[i] == 8'h00) model_enc = 1'b1;
`endif
                end
`ifdef NUNCHUK_ENC_EN
                if (model_ptr == 8'hF0 && d[i] == 8'h55) model_enc = 1'b0;
`endif
                model_ptr = model_ptr + 8'd1;
            end
        end
        check("busy during write", busy, 1);
        i2c_stop();
        check("sda_oe after write stop", sda_oe, 0);
        check("busy after write stop", busy, 0);
        check("reg_ptr after write", reg_ptr, model_ptr);
        check("init_done after write", init_done, model_init);
    endtask

    // Read transaction of n bytes, NACK on the last; optionally change report after byte 0.
    task automatic read_txn(input int n, input logic swap, input logic [8*NB-1:0] new_rep);
        logic       ack;
        logic [7:0] b;
        int         s0;
        s0 = strobe_cnt;
        for (int i = 0; i < n; i++) begin
            int idx;
            idx = int'(model_ptr) + i;
            if (idx < NB) exp_q.push_back(xform(report[8*(NB-1-idx) +: 8]));
            else          exp_q.push_back(xform(8'hFF));
        end
        i2c_start();
        write_byte(8'hA5, ack);
        check("rd addr ack", ack, 1);
        check("busy after match", busy, 1);
        for (int i = 0; i < n; i++) begin
            read_byte(b, i == n - 1);
            check($sformatf("rd byte %0d", i), b, exp_q.pop_front());
            if (swap && i == 0) report = new_rep;
        end
        model_ptr = model_ptr + 8'(n);
        i2c_stop();
        check("rd_strobe pulses", strobe_cnt - s0, 1);
        check("busy after read", busy, 0);
        check("sda_oe after read", sda_oe, 0);
        check("reg_ptr after read", reg_ptr, model_ptr);
    endtask

    initial begin
        logic ack, b0;
        int   o0;

        // Reset state
        tick(5);
        check("reset sda_oe", sda_oe, 0);
        check("reset init_done", init_done, 0);
        check("reset rd_strobe", rd_strobe, 0);
        check("reset busy", busy, 0);
        check("reset reg_ptr", reg_ptr, 0);
        reset = 1'b0;
        tick(5);

        // 1: init write 0x40 <- 0x00
        send_write(8'h40, 8'h00, 8'h00, 2);

        // 2: pointer 0 then 6-byte read
        report = 48'h7F80_1234_56A3;
        send_write(8'h00, 8'h00, 8'h00, 1);
        read_txn(6, 1'b0, '0);

        // 3: wrong address is ignored until STOP
        o0 = oe_cnt;
        i2c_start();
        write_byte(8'hA6, ack);
        check("bad addr no ack", ack, 0);
        write_byte(8'h40, ack);
        check("ignored byte no ack", ack, 0);
        check("busy while ignoring", busy, 0);
        i2c_stop();
        check("sda_oe never asserted", oe_cnt - o0, 0);
        check("init_done unchanged", init_done, model_init);
        check("reg_ptr unchanged", reg_ptr, model_ptr);

        // 4: 7-byte read with filler, report changed mid-read
        report = 48'hDEAD_BEEF_0102;
        send_write(8'h00, 8'h00, 8'h00, 1);
        read_txn(7, 1'b1, 48'h0123_4567_89AB);

        // 5: reset during bit 3 of a read byte, then a clean read
        report = 48'h5011_2233_4455;
        send_write(8'h00, 8'h00, 8'h00, 1);
        i2c_start();
        write_byte(8'hA5, ack);
        check("rst addr ack", ack, 1);
        read_bit(b0);
        read_bit(b0);
        msda = 1'b1; tick(QTR);
        scl  = 1'b1; tick(QTR);
        check("bit 3 driven low", sda_oe, 1);
        reset = 1'b1;
        tick(1);
        check("sda_oe after reset", sda_oe, 0);
        check("busy after reset", busy, 0);
        tick(4);
        check("reg_ptr after reset", reg_ptr, 0);
        check("init_done after reset", init_done, 0);
        reset = 1'b0;
        model_ptr = 8'h00; model_init = 1'b0; model_enc = 1'b0;
        scl = 1'b0; tick(QTR);
        report = 48'hC0FF_EE12_3456;
        read_txn(6, 1'b0, '0);

`ifdef NUNCHUK_ENC_EN
        // 6: legacy init enables encoding, 0xF0 <- 0x55 disables it
        send_write(8'h40, 8'h00, 8'h00, 2);
        report = 48'h7F00_0000_0000;
        send_write(8'h00, 8'h00, 8'h00, 1);
        read_txn(2, 1'b0, '0);
        send_write(8'hF0, 8'h55, 8'h00, 2);
        send_write(8'h00, 8'h00, 8'h00, 1);
        read_txn(1, 1'b0, '0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/i2c_nunchuk_target.md
Name: i2c_nunchuk_target

Overview:
I2C target (responder) that emulates a Nunchuk controller at 7-bit address 0x52. It is the other end of the existing I2C_master link: it accepts the init write and the register-pointer write, and returns a 6-byte report on reads. It is used as a loopback/stand-in peripheral for bench and on-board self-test, with a top-level open-drain pad wrapper driving SDA from sda_oe. SCL is input only; the block never clock-stretches.

Parameters:
ADDR, 7'h52, target address matched against the first byte after START
NUM_BYTES, 6, report length in bytes; report port width is 8*NUM_BYTES
INIT_REG, 8'h40, register whose write sets init_done

Ports:
clk_in  input  1  system clock, must be at least 16x SCL rate
reset  input  1  synchronous, active-high
scl_i  input  1  raw SCL pad input
sda_i  input  1  raw SDA pad input
sda_oe  output  1  1 = pull SDA low; 0 = release
report  input  8*NUM_BYTES  report data; byte 0 = report[8*NUM_BYTES-1 -: 8]
init_done  output  1  level; set by a write to INIT_REG
rd_strobe  output  1  one-cycle pulse when a read transaction ends
busy  output  1  high from an address match until STOP/NACK
reg_ptr  output  8  current register pointer (debug)

Behaviour:
- Reset clears sda_oe, init_done, rd_strobe, busy and reg_ptr to 0. State returns to IDLE.
- Input conditioning:
  - scl_i and sda_i each pass through a 2-FF synchronizer, then one history register.
  - Edges are detected on the synchronized values.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - START or repeated START in any state goes to ADDR with bit count 0 and sda_oe = 0.
  - STOP in any state goes to IDLE with sda_oe = 0 and busy = 0.
- Sampling and driving:
  - Data is sampled on the SCL rising edge.
  - sda_oe changes only on the cycle after an SCL falling edge is detected.
- States:
  - IDLE: waits for START.
  - ADDR: shifts in 8 bits, MSB first. On the 8th rising edge, compare bits [7:1] with ADDR.
    - Match: go to ADDR_ACK and set busy.
    - Mismatch: go to IGNORE, with sda_oe held 0 until STOP/START.
  - ADDR_ACK: sda_oe = 1 from the falling edge after bit 8 until the next falling edge.
    - R/W = 0: go to WR_BYTE; the next byte is the pointer.
    - R/W = 1: capture report into a snapshot register during the ACK (coherent frame), then go to RD_BYTE.
  - WR_BYTE: shift in 8 bits, then go to WR_ACK (ACK driven the same way as ADDR_ACK).
    - First byte of the transaction: reg_ptr <= byte.
    - Later bytes: if reg_ptr == INIT_REG, set init_done. Then reg_ptr <= reg_ptr + 1, wrapping 8'hFF to 8'h00.
  - RD_BYTE: drive the MSB of the shift register on each falling edge. sda_oe = ~bit.
    - Bit source when reg_ptr < NUM_BYTES: snapshot byte reg_ptr.
    - Bit source otherwise: 8'hFF.
    - After the 8th bit: release SDA, increment reg_ptr, go to RD_ACK.
  - RD_ACK: sample SDA on the rising edge.
    - 0 (ACK): load the next byte and go to RD_BYTE.
    - 1 (NACK): pulse rd_strobe, clear busy, go to IGNORE.
- reg_ptr persists across transactions. A read with no prior pointer write starts at the current reg_ptr.
- Reset mid-transfer: sda_oe is 0 on the cycle after reset is sampled high. The block ignores the bus until the next START after reset deasserts.
- A STOP that arrives in RD_BYTE or RD_ACK also pulses rd_strobe.

Optional Feature:
NUNCHUK_ENC_EN.
- Defined:
  - A write of 8'h00 to INIT_REG (legacy init) sets an internal enc flag.
  - A write of 8'h55 to 8'hF0 clears it.
  - While enc = 1, each transmitted byte b becomes ((b ^ 8'h17) + 8'h17) mod 256. This includes the 8'hFF filler bytes.
- Undefined: bytes are sent plain, with no enc flag or logic.

Test Plan:
1. Write addr 0x52/W, then 0x40, then 0x00 at 100 kHz SCL with a 12 MHz clk -> three ACKs, init_done = 1, reg_ptr = 0x41, sda_oe = 0 after STOP.
2. Write 0x52/W with pointer 0x00, STOP, then 0x52/R for 6 bytes, NACK on the last; report = 48'h7F80_1234_56A3 -> master receives 7F,80,12,34,56,A3; one rd_strobe pulse; busy falls.
3. Address 0x53/W -> no ACK (sda_oe never 1), state IGNORE until STOP, init_done unchanged.
4. Read 7 bytes from ptr 0 -> 7th byte = 0xFF. report changed mid-read -> bytes 1..6 still come from the snapshot taken at the address ACK.
5. Assert reset during bit 3 of a read byte -> sda_oe = 0 next cycle, busy = 0. A following full read from START succeeds.
6. With NUNCHUK_ENC_EN: legacy init, then read with report byte 0 = 0x7F -> 0x7F^0x17 = 0x68, +0x17 = 0x7F, received 0x7F; byte 0x00 -> received 0x2E.
